// File: rtl/axil_shadow_register_bank_if.sv
// axi_lite: AXI4-lite channel bundle shared by the register bank and its initiator.
`default_nettype none

interface axi_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/axil_shadow_register_bank.sv
// axil_shadow_register_bank: AXI-lite shadow/active parameter bank; an update
// pulse moves every shadow register into the active set on a single edge.
`default_nettype none

module axil_shadow_register_bank #(
  parameter int          N_REGISTERS    = 9,
  parameter logic [31:0] BASE_ADDRESS   = 32'h0,
  parameter int          REGISTER_WIDTH = 32
) (
  input  logic                                         clock,
  input  logic                                         reset,
  axi_lite.slave                                       axil,
  input  logic                                         update,
  output logic [N_REGISTERS-1:0][REGISTER_WIDTH-1:0]   active_registers,
  output logic                                         write_event,
  output logic [$clog2(N_REGISTERS)-1:0]               write_index
);

  localparam int          IDX_W       = $clog2(N_REGISTERS);
  localparam int          STRB_W      = REGISTER_WIDTH / 8;
  localparam logic [31:0] C_N         = 32'(N_REGISTERS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [REGISTER_WIDTH-1:0] shadow [N_REGISTERS];

  logic                      aw_held;
  logic [31:0]               aw_addr;
  logic                      w_held;
  logic [REGISTER_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]         w_strb;
  logic                      bvalid;
  logic [1:0]                bresp;
  logic                      rvalid;
  logic [REGISTER_WIDTH-1:0] rdata;
  logic [1:0]                rresp;

  logic                      aw_ready, w_ready, ar_ready;
  logic                      aw_fire, w_fire, ar_fire, commit;
  logic [31:0]               wr_addr;
  logic [REGISTER_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic                      wr_ok, rd_ok;
  logic [IDX_W-1:0]          wr_idx, rd_idx;

  function automatic logic addr_in_range(input logic [31:0] a);
    return (a >= BASE_ADDRESS) && (((a - BASE_ADDRESS) >> 2) < C_N);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDRESS) >> 2);
  endfunction

  always_comb begin
    aw_ready = !aw_held && !bvalid && !reset;
    w_ready  = !w_held  && !bvalid && !reset;
    ar_ready = !rvalid && !reset;
    aw_fire  = axil.awvalid && aw_ready;
    w_fire   = axil.wvalid  && w_ready;
    ar_fire  = axil.arvalid && ar_ready;
    // Held flags stay set until the B handshake, so bvalid gates re-commit.
    commit   = (aw_held || aw_fire) && (w_held || w_fire) && !bvalid;
    wr_addr  = aw_held ? aw_addr : axil.awaddr;
    wr_data  = w_held  ? w_data  : axil.wdata;
    wr_strb  = w_held  ? w_strb  : axil.wstrb;
    wr_ok    = addr_in_range(wr_addr);
    wr_idx   = addr_index(wr_addr);
    rd_ok    = addr_in_range(axil.araddr);
    rd_idx   = addr_index(axil.araddr);
  end

  assign axil.awready = aw_ready;
  assign axil.wready  = w_ready;
  assign axil.arready = ar_ready;
  assign axil.bvalid  = bvalid;
  assign axil.bresp   = bresp;
  assign axil.rvalid  = rvalid;
  assign axil.rdata   = rdata;
  assign axil.rresp   = rresp;

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_held     <= 1'b0;
      aw_addr     <= '0;
      w_held      <= 1'b0;
      w_data      <= '0;
      w_strb      <= '0;
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
      rvalid      <= 1'b0;
      rdata       <= '0;
      rresp       <= RESP_OKAY;
      write_event <= 1'b0;
      write_index <= '0;
      for (int i = 0; i < N_REGISTERS; i++) begin
        shadow[i]           <= '0;
        active_registers[i] <= '0;
      end
    end else begin
      write_event <= 1'b0;

      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_addr <= axil.awaddr;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= axil.wdata;
        w_strb <= axil.wstrb;
      end

      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          write_event <= 1'b1;
          write_index <= wr_idx;
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) shadow[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end else if (bvalid && axil.bready) begin
        bvalid  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end

      // Nonblocking reads of shadow give the pre-write value on a commit edge.
      if (ar_fire) begin
        rvalid <= 1'b1;
        rdata  <= rd_ok ? shadow[rd_idx] : '0;
        rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid && axil.rready) begin
        rvalid <= 1'b0;
      end

      if (update) begin
        for (int i = 0; i < N_REGISTERS; i++) active_registers[i] <= shadow[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axil_shadow_register_bank.sv
// tb_axil_shadow_register_bank: randomized and directed checks of the register bank
// against an array-based model of shadow/active contents.
`default_nettype none

module tb_axil_shadow_register_bank;

  logic clock = 1'b0;
  logic reset;
  logic update;
  logic [8:0][31:0] active_registers;
  logic write_event;
  logic [3:0] write_index;

  always #5 clock = ~clock;

  axi_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

  axil_shadow_register_bank #(
    .N_REGISTERS(9), .BASE_ADDRESS(32'h0), .REGISTER_WIDTH(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .axil(axil),
    .update(update),
    .active_registers(active_registers),
    .write_event(write_event),
    .write_index(write_index)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_shadow [9];
  logic [31:0] m_active [9];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    return (a / 4) < 9;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
  endtask

  task automatic check_active(input string tag);
    for (int i = 0; i < 9; i++) check(tag, active_registers[i], m_active[i]);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_d, input int w_d,
                          input int b_d, input bit upd);
    int cyc = 0;
    int since = 0;
    bit aw_done = 0, w_done = 0, committed = 0, done = 0;
    bit aw_f, w_f, will_commit;
    bit ok = m_in_range(addr);
    while (!done) begin
      axil.awvalid = !aw_done && (cyc >= aw_d);
      axil.awaddr  = addr;
      axil.wvalid  = !w_done && (cyc >= w_d);
      axil.wdata   = data;
      axil.wstrb   = strb;
      axil.bready  = committed && (cyc >= b_d);
      aw_f = axil.awvalid && axil.awready;
      w_f  = axil.wvalid && axil.wready;
      will_commit = !committed && (aw_done || aw_f) && (w_done || w_f);
      update = will_commit && upd;
      if (committed) begin
        if (since == 0) begin
          check("bvalid_latency", axil.bvalid, 1'b1);
          check("write_event", write_event, ok);
          if (ok) check("write_index", write_index, addr / 4);
        end else if (since == 1) begin
          check("write_event_pulse", write_event, 1'b0);
        end
        if (axil.bvalid && axil.bready) begin
          check("bresp", axil.bresp, ok ? 2'b00 : 2'b10);
          done = 1;
        end
        since++;
      end
      @(negedge clock);
      if (will_commit) begin
        committed = 1;
        if (upd) m_active = m_shadow;
        if (ok) begin
          for (int b = 0; b < 4; b++)
            if (strb[b]) m_shadow[addr / 4][8*b +: 8] = data[8*b +: 8];
        end
      end
      aw_done |= aw_f;
      w_done  |= w_f;
      cyc++;
      if (cyc > 60 && !done) begin
        check("write_timeout", 1'b0, 1'b1);
        done = 1;
      end
    end
    axil.awvalid = 0;
    axil.wvalid  = 0;
    axil.bready  = 0;
    update       = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold);
    int n = 0;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    axil.arvalid = 1;
    axil.araddr  = addr;
    axil.rready  = 0;
    while (!axil.arready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!axil.arready) check("ar_timeout", 1'b0, 1'b1);
    exp_data = m_in_range(addr) ? m_shadow[addr / 4] : 32'h0;
    exp_resp = m_in_range(addr) ? 2'b00 : 2'b10;
    @(negedge clock);
    axil.arvalid = 0;
    for (int k = 0; k <= hold; k++) begin
      check("rvalid", axil.rvalid, 1'b1);
      check("rdata", axil.rdata, exp_data);
      check("rresp", axil.rresp, exp_resp);
      if (hold > 0) check("arready_blocked", axil.arready, 1'b0);
      axil.rready = (k == hold);
      @(negedge clock);
    end
    axil.rready = 0;
    check("rvalid_drop", axil.rvalid, 1'b0);
  endtask

  task automatic do_update();
    update = 1;
    @(negedge clock);
    update = 0;
    m_active = m_shadow;
    check_active("active_after_update");
  endtask

  logic [31:0] plan_data [9] = '{32'h1, 32'h154, 32'h2645, 32'h64, 32'h333,
                                 32'h222, 32'h555, 32'h666, 32'h777};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; update = 0;
    axil.awvalid = 0; axil.awaddr = 0; axil.wvalid = 0; axil.wdata = 0;
    axil.wstrb = 0; axil.bready = 0; axil.arvalid = 0; axil.araddr = 0;
    axil.rready = 0;
    model_clear();
    repeat (3) @(negedge clock);
    check("awready_in_reset", axil.awready, 1'b0);
    check("wready_in_reset", axil.wready, 1'b0);
    check("arready_in_reset", axil.arready, 1'b0);
    reset = 0;
    @(negedge clock);
    check("bvalid_reset", axil.bvalid, 1'b0);
    check("rvalid_reset", axil.rvalid, 1'b0);
    check("rdata_reset", axil.rdata, 32'h0);
    check("bresp_reset", axil.bresp, 2'b00);
    check("rresp_reset", axil.rresp, 2'b00);
    check("write_event_reset", write_event, 1'b0);
    check("write_index_reset", write_index, 4'h0);
    check("awready_after_reset", axil.awready, 1'b1);
    check_active("active_reset");

    // Nine in-range writes; active must not move until update.
    for (int i = 0; i < 9; i++) do_write(32'(i * 4), plan_data[i], 4'hF, 0, 0, 0, 0);
    check_active("active_before_update");
    do_update();

    // AW three cycles ahead of W.
    do_write(32'h08, 32'hABCD, 4'hF, 0, 3, 0, 0);
    do_read(32'h08, 0);

    // Byte strobe on reg 0.
    do_write(32'h00, 32'hFFFF_FFFF, 4'b0010, 0, 0, 0, 0);
    do_read(32'h00, 0);

    // Out of range accesses.
    do_write(32'h24, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
    do_read(32'h40, 0);

    // Write committing together with update.
    do_write(32'h0C, 32'h55, 4'hF, 1, 0, 2, 1);
    check_active("active_collision");
    do_update();

    // Read backpressure.
    do_read(32'h04, 5);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 3))
        0, 1: do_write(32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3)), $urandom,
                       4'($urandom_range(0, 15)), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 6),
                       $urandom_range(0, 3) == 0);
        2: do_read(32'($urandom_range(0, 17) * 4), $urandom_range(0, 2));
        default: do_update();
      endcase
    end
    do_update();

    // Reset while a B response is pending.
    axil.awvalid = 1; axil.awaddr = 32'h04; axil.wvalid = 1;
    axil.wdata = 32'h99; axil.wstrb = 4'hF; axil.bready = 0;
    @(negedge clock);
    axil.awvalid = 0; axil.wvalid = 0;
    check("bvalid_before_reset", axil.bvalid, 1'b1);
    reset = 1;
    @(negedge clock);
    model_clear();
    check("bvalid_after_reset", axil.bvalid, 1'b0);
    check_active("active_after_reset");
    reset = 0;
    @(negedge clock);
    do_read(32'h04, 0);
    do_update();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
